// File: rtl/operand_fetch.sv
// Operand fetch stage: paces the A/B address generator, issues SRAM reads and buffers the
// returned operand pairs in a credit-controlled FIFO. Optional stall counter via OPFETCH_PERF_EN.
module operand_fetch #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRAM_AW = 10,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         beats,
    output logic               gen_en,
    input  logic [31:0]        rdaddr_A,
    input  logic [31:0]        rdaddr_B,
    output logic               sram_a_en,
    output logic               sram_b_en,
    output logic [SRAM_AW-1:0] sram_a_addr,
    output logic [SRAM_AW-1:0] sram_b_addr,
    input  logic [DATA_W-1:0]  sram_a_rdata,
    input  logic [DATA_W-1:0]  sram_b_rdata,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [DATA_W-1:0]  op_a,
    output logic [DATA_W-1:0]  op_b,
`ifdef OPFETCH_PERF_EN
    output logic [31:0]        perf_stall,
`endif
    output logic               busy,
    output logic               done
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        remaining_q, remaining_d;
    logic              strobe_q;
    logic              capture_q;
    logic [1:0]        inflight;
    logic [SW-1:0]     credit_sum;
    logic              credit_ok;

    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     occ_q, occ_d;
    logic              push, pop;

    logic              unused_addr_bits;

    // Beats issued to SRAM but not yet written into the FIFO hold a credit each.
    assign inflight   = {1'b0, strobe_q} + {1'b0, capture_q};
    assign credit_sum = SW'(occ_q) + SW'(inflight);
    assign credit_ok  = credit_sum < SW'(DEPTH);

    assign gen_en = (state_q == StRun) && (remaining_q != '0) && credit_ok;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

    assign sram_a_en   = strobe_q;
    assign sram_b_en   = strobe_q;
    // Address is forced to zero when no read is issued so reset leaves the bus quiet.
    assign sram_a_addr = strobe_q ? rdaddr_A[SRAM_AW:1] : '0;
    assign sram_b_addr = strobe_q ? rdaddr_B[SRAM_AW:1] : '0;

    assign unused_addr_bits = ^{rdaddr_A[31:SRAM_AW+1], rdaddr_A[0],
                                rdaddr_B[31:SRAM_AW+1], rdaddr_B[0]};

    assign push     = capture_q;
    assign op_valid = (occ_q != '0);
    assign pop      = op_valid && op_ready;
    assign op_a     = mem_a_q[rd_ptr_q];
    assign op_b     = mem_b_q[rd_ptr_q];

    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (beats != '0) begin
                        state_d     = StRun;
                        remaining_d = beats;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (gen_en) begin
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Look at next occupancy so the final pop and DONE line up without a bubble.
                if ((inflight == 2'd0) && (occ_d == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            strobe_q    <= 1'b0;
            capture_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            strobe_q    <= gen_en;
            capture_q   <= strobe_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            if (push) begin
                mem_a_q[wr_ptr_q] <= sram_a_rdata;
                mem_b_q[wr_ptr_q] <= sram_b_rdata;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

`ifdef OPFETCH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            perf_q <= '0;
        end else if (op_valid && !op_ready && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall = perf_q;
`endif

    // The credit rule must keep pushes away from a full FIFO.
    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (occ_q == CW'(DEPTH))));

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: generator/SRAM models feed a scoreboard of operand pairs.
module tb_operand_fetch;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SRAM_AW = 10;
    localparam int unsigned DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [7:0]         beats = '0;
    logic               gen_en;
    logic [31:0]        rdaddr_A, rdaddr_B;
    logic               sram_a_en, sram_b_en;
    logic [SRAM_AW-1:0] sram_a_addr, sram_b_addr;
    logic [DATA_W-1:0]  sram_a_rdata = '0;
    logic [DATA_W-1:0]  sram_b_rdata = '0;
    logic               op_valid;
    logic               op_ready = 1'b1;
    logic [DATA_W-1:0]  op_a, op_b;
    logic               busy, done;
`ifdef OPFETCH_PERF_EN
    logic [31:0]        perf_stall;
`endif

    operand_fetch #(.DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .beats(beats), .gen_en(gen_en),
        .rdaddr_A(rdaddr_A), .rdaddr_B(rdaddr_B),
        .sram_a_en(sram_a_en), .sram_b_en(sram_b_en),
        .sram_a_addr(sram_a_addr), .sram_b_addr(sram_b_addr),
        .sram_a_rdata(sram_a_rdata), .sram_b_rdata(sram_b_rdata),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
`ifdef OPFETCH_PERF_EN
        .perf_stall(perf_stall),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Address generator model: address appears the cycle after gen_en.
    logic [7:0]  tile_tag = '0;
    logic        use_ovr  = 1'b0;
    logic [31:0] ovr_a    = '0;
    logic [31:0] ovr_b    = '0;
    int unsigned gen_idx;

    function automatic logic [31:0] gen_addr_a(input int unsigned idx);
        if (use_ovr) return ovr_a;
        return 32'h0000_0100 + 32'(idx << 1);
    endfunction

    function automatic logic [31:0] gen_addr_b(input int unsigned idx);
        if (use_ovr) return ovr_b;
        return 32'h0000_0600 + 32'(idx << 1);
    endfunction

    function automatic logic [31:0] sram_word(input logic [7:0] tag, input logic [3:0] bank,
                                              input logic [9:0] a);
        return {tag, bank, 10'b0, a};
    endfunction

    function automatic logic [63:0] exp_pair(input int unsigned idx);
        logic [31:0] a, b;
        a = gen_addr_a(idx);
        b = gen_addr_b(idx);
        return {sram_word(tile_tag, 4'hA, a[SRAM_AW:1]), sram_word(tile_tag, 4'hB, b[SRAM_AW:1])};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_idx  <= 0;
            rdaddr_A <= '0;
            rdaddr_B <= '0;
        end else if (gen_en) begin
            rdaddr_A <= gen_addr_a(gen_idx);
            rdaddr_B <= gen_addr_b(gen_idx);
            gen_idx  <= gen_idx + 1;
        end
    end

    always @(posedge clk) begin
        if (sram_a_en) sram_a_rdata <= sram_word(tile_tag, 4'hA, sram_a_addr);
        if (sram_b_en) sram_b_rdata <= sram_word(tile_tag, 4'hB, sram_b_addr);
    end

    // Monitor / scoreboard, sampled on the falling edge.
    logic [63:0]  exp_q [$];
    int           cyc = 0;
    int           t0 = 0;
    int           gen_cnt = 0, gen_first = -1, gen_last = -1;
    int           strobe_cnt = 0, done_cyc = -1, pop_cnt = 0;
    logic [9:0]   last_addr_a = '0, last_addr_b = '0;
`ifdef OPFETCH_PERF_EN
    int           stall_cnt = 0;
    logic [31:0]  perf_at_done = '0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else if (start && !busy) begin
            t0         <= cyc;
            gen_cnt    <= 0;
            gen_first  <= -1;
            gen_last   <= -1;
            strobe_cnt <= 0;
            done_cyc   <= -1;
            pop_cnt    <= 0;
`ifdef OPFETCH_PERF_EN
            stall_cnt  <= 0;
`endif
        end else begin
            if (op_valid && op_ready) begin
                if (exp_q.size() == 0) check_eq("pop_unexpected", 64'd1, 64'd0);
                else check_eq("operand_pair", {op_a, op_b}, exp_q.pop_front());
                pop_cnt <= pop_cnt + 1;
            end
            if (gen_en) begin
                exp_q.push_back(exp_pair(gen_idx));
                gen_cnt  <= gen_cnt + 1;
                gen_last <= cyc - t0;
                if (gen_first < 0) gen_first <= cyc - t0;
            end
            if (sram_a_en) begin
                strobe_cnt  <= strobe_cnt + 1;
                last_addr_a <= sram_a_addr;
                last_addr_b <= sram_b_addr;
            end
            if (done) done_cyc <= cyc - t0;
`ifdef OPFETCH_PERF_EN
            if (op_valid && !op_ready) stall_cnt <= stall_cnt + 1;
            if (done) perf_at_done <= perf_stall;
`endif
        end
    end

    task automatic start_tile(input logic [7:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        beats = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int i = 0;
        while (done_cyc < 0 && i < limit) begin
            @(posedge clk);
            i++;
        end
        check_eq("done_seen", 64'(done_cyc >= 0), 64'd1);
        @(posedge clk); #1;
        check_eq("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ctrl", 64'({gen_en, sram_a_en, sram_b_en, op_valid, busy, done}), 64'd0);
        check_eq("rst_addr", 64'({sram_a_addr, sram_b_addr}), 64'd0);
        check_eq("rst_ops", {op_a, op_b}, 64'd0);
        rst = 1'b1;

        // Full-rate tile.
        tile_tag = 8'h01;
        op_ready = 1'b1;
        start_tile(8'd8);
        wait_done(40);
        check_eq("t8_done_cycle", 64'(done_cyc), 64'd12);
        check_eq("t8_gen_cnt", 64'(gen_cnt), 64'd8);
        check_eq("t8_gen_first", 64'(gen_first), 64'd1);
        check_eq("t8_gen_last", 64'(gen_last), 64'd8);
        check_eq("t8_pop_cnt", 64'(pop_cnt), 64'd8);
        check_eq("t8_sb_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure until cycle 20.
        tile_tag = 8'h02;
        op_ready = 1'b0;
        start_tile(8'd6);
        repeat (18) @(posedge clk);
        #1;
        check_eq("bp_gen_cnt", 64'(gen_cnt), 64'd4);
        check_eq("bp_gen_held", 64'(gen_en), 64'd0);
        check_eq("bp_full_valid", 64'(op_valid), 64'd1);
        @(posedge clk); #1;
        op_ready = 1'b1;
        wait_done(60);
        check_eq("bp_gen_total", 64'(gen_cnt), 64'd6);
        check_eq("bp_pop_cnt", 64'(pop_cnt), 64'd6);
        check_eq("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Empty tile.
        tile_tag = 8'h03;
        start_tile(8'd0);
        wait_done(10);
        check_eq("z_done_cycle", 64'(done_cyc), 64'd1);
        check_eq("z_gen_cnt", 64'(gen_cnt), 64'd0);
        check_eq("z_strobe_cnt", 64'(strobe_cnt), 64'd0);

        // Address bit slicing.
        tile_tag = 8'h04;
        use_ovr  = 1'b1;
        ovr_a    = 32'hFFFF_F847;
        ovr_b    = 32'h0000_07FE;
        start_tile(8'd1);
        wait_done(20);
        check_eq("addr_a_slice", 64'(last_addr_a), 64'h023);
        check_eq("addr_b_slice", 64'(last_addr_b), 64'h3FF);
        check_eq("addr_pop_cnt", 64'(pop_cnt), 64'd1);
        use_ovr = 1'b0;

        // Reset mid-tile with two beats in flight.
        tile_tag = 8'h05;
        start_tile(8'd8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_ctrl", 64'({gen_en, sram_a_en, sram_b_en, op_valid, busy, done}),
                 64'd0);
        check_eq("mid_rst_addr", 64'({sram_a_addr, sram_b_addr}), 64'd0);
        check_eq("mid_rst_ops", {op_a, op_b}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        tile_tag = 8'h06;
        start_tile(8'd3);
        wait_done(30);
        check_eq("post_rst_done_cycle", 64'(done_cyc), 64'd7);
        check_eq("post_rst_pop_cnt", 64'(pop_cnt), 64'd3);
        check_eq("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef OPFETCH_PERF_EN
        // Stall counter with a toggling consumer.
        tile_tag = 8'h07;
        op_ready = 1'b1;
        start_tile(8'd4);
        for (int i = 0; i < 80 && done_cyc < 0; i++) begin
            @(posedge clk); #1;
            op_ready = ~op_ready;
        end
        check_eq("perf_done_seen", 64'(done_cyc >= 0), 64'd1);
        check_eq("perf_at_done", 64'(perf_at_done), 64'(stall_cnt));
        check_eq("perf_nonzero", 64'(stall_cnt != 0), 64'd1);
        op_ready = 1'b1;
        start_tile(8'd1);
        check_eq("perf_cleared", 64'(perf_stall), 64'd0);
        wait_done(20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand fetch stage directly downstream of the A/B address generator unit in the tensor-core datapath. Paces the generator through its `en_in` input, converts its `rdaddr_A`/`rdaddr_B` outputs into SRAM read requests, and captures the returned words in a credit-controlled FIFO. Presents paired A/B operands to the systolic array edge with a valid/ready handshake. One tile of `beats` fetches runs per `start`.

## Interface
Parameters:
- `DATA_W`, 32, width of one SRAM word and one operand.
- `SRAM_AW`, 10, SRAM word-address width.
- `DEPTH`, 4, operand FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `beats`  in  8  fetches in the tile, latched on accepted `start`.
- `gen_en`  out  1  drives the address generator `en_in`.
- `rdaddr_A`, `rdaddr_B`  in  32 each  generator outputs, valid the cycle after `gen_en`.
- `sram_a_en`, `sram_b_en`  out  1 each  SRAM read strobes.
- `sram_a_addr`, `sram_b_addr`  out  SRAM_AW each  `rdaddr_X[SRAM_AW:1]`.
- `sram_a_rdata`, `sram_b_rdata`  in  DATA_W each  read data, valid one cycle after the strobe.
- `op_valid`  out  1  FIFO head valid.
- `op_ready`  in  1  array accepts the head.
- `op_a`, `op_b`  out  DATA_W each  head operands.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle tile-complete pulse.
- `perf_stall`  out  32  present only with `OPFETCH_PERF_EN`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on `start` with `beats != 0`; `remaining` is loaded with `beats`. On `start` with `beats == 0`, go IDLE -> DONE with no fetch. `start` is ignored outside IDLE.
- RUN:
  - `gen_en = (remaining != 0) && (occ + inflight < DEPTH)`.
  - `occ` is the FIFO count; `inflight` (0..2) counts issued but uncaptured beats.
  - Each `gen_en` decrements `remaining`.
  - RUN -> DRAIN when `remaining` reaches 0.
- SRAM request: the `gen_en` registered by one cycle drives both `sram_a_en` and `sram_b_en`. Addresses are taken combinationally from `rdaddr_A`/`rdaddr_B` in that same cycle.
- Capture: the strobe registered by one cycle is the FIFO push of the pair {`sram_a_rdata`, `sram_b_rdata`}.
- Pop happens on `op_valid && op_ready`. A simultaneous push and pop leaves `occ` unchanged. Pointers wrap modulo DEPTH.
- The credit rule guarantees push never occurs when full. Overflow is unreachable and is asserted against in simulation.
- DRAIN -> DONE when `inflight == 0` and `occ == 0`. DONE -> IDLE unconditionally; `done` is high only in the DONE state.
- `op_a`/`op_b` reflect the FIFO head and are don't-care while `op_valid` is 0.
- Reset mid-tile: all state, counters and the FIFO clear immediately. Any in-flight SRAM data is discarded. The generator is reset by the same `rst`.

## Timing
- Reset values: `gen_en`, `sram_*_en`, `op_valid`, `busy`, `done` = 0; `sram_*_addr` = 0; `op_a`/`op_b` = 0; `perf_stall` = 0.
- `start` at cycle 0 gives `busy` and the first `gen_en` at cycle 1.
- `gen_en` at cycle t gives the SRAM strobe at t+1, data at t+2, and `op_valid` at t+3.
- With `op_ready` held high and DEPTH >= 4, throughput is one beat per cycle. `N` beats give `done` at cycle N+4 after `start`.
- Backpressure: while `op_ready` = 0, `gen_en` stops within one cycle once `occ + inflight == DEPTH`.
- `gen_en` resumes in the cycle after the pop that frees a credit.

## Configuration
- `OPFETCH_PERF_EN` defined:
  - `perf_stall` exists.
  - It increments each cycle `op_valid && !op_ready`, saturating at 2^32-1.
  - It clears on `rst` and on an accepted `start`.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- `beats=8`, `op_ready` held 1, SRAM returning address-tagged data -> 8 pairs in generator order, `gen_en` high cycles 1-8, `done` at cycle 12.
- `beats=6`, `op_ready=0` until cycle 20 -> `gen_en` pulses exactly 4 times and holds 0; after release the remaining 2 fetch, all 6 delivered in order, no overflow.
- `beats=0` -> `done` the cycle after `start`; no `gen_en` or SRAM strobe.
- `rdaddr_A=0x0000_0046` -> `sram_a_addr=0x023` (bits 10:1).
- `rst` low mid-tile with 2 in flight -> all outputs return to reset values the same cycle; a following `beats=3` tile delivers exactly 3 fresh beats with no stale data.
- `OPFETCH_PERF_EN`, `op_ready` toggling 1/0 with 4 valid-stalled cycles -> `perf_stall=4` at `done`; a second `start` resets it to 0.
